// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI byte sequencer
// Contents: sequencer FSM state enum, controller busy length, default FIFO depth.

package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } spi_state_e;

    localparam int SPI_BUSY_CYCLES        = 16;
    localparam int SPI_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - byte-wide synchronous FIFO with clear
// Ports: clk, rst_n (async, active-low); push/push_data write the tail;
//        pop drops the head; clear empties the FIFO and wins over push/pop;
//        full/empty status; head is the current head byte (combinational).

module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clear,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A pop on an empty FIFO is dropped, so a same-cycle push into an
        // empty FIFO only becomes visible next cycle. A push on a full FIFO
        // is accepted only when a pop frees the slot in the same cycle.
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q != FULL_CNT) || pop_ok);

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_byte_seq.sv
// rtl/spi_byte_seq.sv - TX/RX byte sequencer in front of the SPI shift controller
// Ports: clk, rst_n (async, active-low).
//        Register side: wr_data/wr_en push TX; rd_en pops RX, rd_data is RX head;
//        flush clears both queues; rx_ignore drops received bytes;
//        tx_full, rx_valid, active status.
//        Controller side: txdata/txstart (registered) out; rxdata/busy in.
// Build option: SPI_RXFIFO_EN selects a DEPTH-entry RX FIFO (launch stalls
//        while RX is full); without it RX is a single overwrite register.

module spi_byte_seq
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    input  logic       flush,
    input  logic       rx_ignore,
    output logic       tx_full,
    output logic       rx_valid,
    output logic       active,
    output logic [7:0] txdata,
    output logic       txstart,
    input  logic [7:0] rxdata,
    input  logic       busy
);

    spi_state_e state_q, state_d;
    logic [7:0] txdata_q, txdata_d;
    logic       txstart_q, txstart_d;
    logic       drop_q, drop_d;

    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;
    logic       rx_push;
    logic       rx_full;
    logic       launch_ok;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_pop),
        .clear     (flush),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    always_comb begin
        state_d   = state_q;
        txdata_d  = txdata_q;
        txstart_d = 1'b0;
        drop_d    = drop_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;

        // A flush in IDLE empties TX this cycle, so the head must not launch.
        launch_ok = !tx_empty && (rx_ignore || !rx_full) && !flush;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (launch_ok) begin
                    txdata_d  = tx_head;
                    txstart_d = 1'b1;
                    tx_pop    = 1'b1;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                // Controller samples txstart at the end of this cycle.
                if (flush) begin
                    drop_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (!busy) begin
                    rx_push = !rx_ignore && !drop_q && !flush;
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            txdata_q  <= 8'h00;
            txstart_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            txdata_q  <= txdata_d;
            txstart_q <= txstart_d;
            drop_q    <= drop_d;
        end
    end

`ifdef SPI_RXFIFO_EN
    logic rx_empty;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rxdata),
        .pop       (rd_en),
        .clear     (flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rd_data)
    );

    assign rx_valid = !rx_empty;
`else
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_valid_q, rx_valid_d;

    always_comb begin
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        if (rd_en) begin
            rx_valid_d = 1'b0;
        end
        // A freshly received byte wins over a same-cycle read.
        if (rx_push) begin
            rx_hold_d  = rxdata;
            rx_valid_d = 1'b1;
        end
        if (flush) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // The holding register never back-pressures the launch.
    assign rx_full  = 1'b0;
    assign rd_data  = rx_hold_q;
    assign rx_valid = rx_valid_q;
`endif

    assign txdata  = txdata_q;
    assign txstart = txstart_q;
    assign active  = !tx_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_byte_seq.sv
// tb/tb_spi_byte_seq.sv - self-checking bench for spi_byte_seq with loopback controller model

module tb_spi_byte_seq;
    import spi_pkg::*;

    localparam int DEPTH = SPI_FIFO_DEPTH_DEFAULT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       flush = 1'b0;
    logic       rx_ignore = 1'b0;
    logic       tx_full;
    logic       rx_valid;
    logic       active;
    logic [7:0] txdata;
    logic       txstart;
    logic [7:0] rxdata;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         ts_cyc[$];
    logic       txstart_prev = 1'b0;
    logic [7:0] mon_exp;

    typedef struct {
        logic [7:0] data;
        logic       ign;
        logic       exp_valid;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_byte_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .flush     (flush),
        .rx_ignore (rx_ignore),
        .tx_full   (tx_full),
        .rx_valid  (rx_valid),
        .active    (active),
        .txdata    (txdata),
        .txstart   (txstart),
        .rxdata    (rxdata),
        .busy      (busy)
    );

    // Behavioural controller: busy for SPI_BUSY_CYCLES clocks after txstart,
    // MISO looped to MOSI so the received byte equals the sent byte.
    int busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            busy_cnt <= 0;
            rxdata   <= 8'h00;
        end else if (txstart) begin
            busy     <= 1'b1;
            busy_cnt <= SPI_BUSY_CYCLES - 1;
            rxdata   <= txdata;
        end else if (busy) begin
            if (busy_cnt == 0) busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_model_push(input logic [7:0] b);
`ifdef SPI_RXFIFO_EN
        rx_exp.push_back(b);
`else
        rx_exp.delete();
        rx_exp.push_back(b);
`endif
    endtask

    // txstart monitor / TX scoreboard
    always @(negedge clk) begin
        if (rst_n && txstart) begin
            check("txstart_while_busy", busy, 0);
            check("txstart_back_to_back", txstart_prev, 0);
            if (tx_exp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_txstart: txdata=0x%0h, expected no txstart", txdata);
            end else begin
                mon_exp = tx_exp.pop_front();
                check("txdata", txdata, mon_exp);
                if (!rx_ignore) rx_model_push(mon_exp);
            end
            ts_cyc.push_back(cyc);
        end
        txstart_prev = rst_n && txstart;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input logic accept);
        wr_data = b;
        wr_en   = 1'b1;
        if (accept) tx_exp.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (active && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, active, 0);
    endtask

    task automatic wait_busy(input string name, input logic level, input int budget);
        int n = 0;
        while (busy != level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, level);
    endtask

    task automatic rd_check(input string name);
        if (rx_exp.size() > 0) begin
            check({name, "_rx_valid"}, rx_valid, 1);
            check({name, "_rd_data"}, rd_data, rx_exp[0]);
            void'(rx_exp.pop_front());
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end else begin
            check({name, "_rx_empty"}, rx_valid, 0);
        end
    endtask

    task automatic drain_rx(input string name);
        int guard = 0;
        while (rx_exp.size() > 0 && guard < 2 * DEPTH + 2) begin
            rd_check(name);
            guard++;
        end
        rd_check(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ts0;

        vecs[0] = '{data: 8'h55, ign: 1'b1, exp_valid: 1'b0};
        vecs[1] = '{data: 8'hAA, ign: 1'b1, exp_valid: 1'b0};
        vecs[2] = '{data: 8'h96, ign: 1'b0, exp_valid: 1'b1};
        vecs[3] = '{data: 8'h00, ign: 1'b0, exp_valid: 1'b1};
        vecs[4] = '{data: 8'hFF, ign: 1'b1, exp_valid: 1'b0};

        // Reset values
        step(3);
        check("rst_txdata", txdata, 8'h00);
        check("rst_txstart", txstart, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_active", active, 0);
        check("rst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        step(2);

        // Launch latency and RX timing for a single byte
        wr_data = 8'hA5;
        wr_en   = 1'b1;
        tx_exp.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        check("lat_c1_txstart", txstart, 0);
        check("lat_c1_active", active, 1);
        @(negedge clk);
        check("lat_c2_txstart", txstart, 1);
        check("lat_c2_busy", busy, 0);
        @(negedge clk);
        check("lat_c3_busy", busy, 1);
        check("lat_c3_txstart", txstart, 0);
        n = 3;
        while (!rx_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_cycle", n, 20);
        check("single_active_done", active, 0);
        drain_rx("single");

        // Five consecutive pushes fill the 4-entry TX queue; a sixth is dropped
`ifdef SPI_RXFIFO_EN
        rx_ignore = 1'b1;
`endif
        ts0 = ts_cyc.size();
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        check("burst_tx_full", tx_full, 1);
        push(8'h06, 1'b0);
        check("burst_tx_full_hold", tx_full, 1);
        wait_idle("burst_idle", 200);
        check("burst_count", ts_cyc.size() - ts0, 5);
        for (int i = 1; i < 5 && ts0 + i < ts_cyc.size(); i++)
            check("burst_spacing", ts_cyc[ts0 + i] - ts_cyc[ts0 + i - 1], 19);
        drain_rx("burst");
        rx_ignore = 1'b0;

        // Flush mid-WAIT with two bytes queued
        ts0 = ts_cyc.size();
        push(8'h3C, 1'b1);
        push(8'h3D, 1'b1);
        push(8'h3E, 1'b1);
        wait_busy("flush_busy_rise", 1'b1, 10);
        step(8);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        check("flush_tx_full", tx_full, 0);
        check("flush_active_inflight", active, 1);
        wait_busy("flush_busy_fall", 1'b0, 20);
        step(1);
        check("flush_active_after", active, 0);
        check("flush_rx_valid", rx_valid, 0);
        step(40);
        check("flush_no_more_txstart", ts_cyc.size() - ts0, 1);
        push(8'h42, 1'b1);
        wait_idle("post_flush_idle", 60);
        drain_rx("post_flush");

        // Table-driven rx_ignore / single-byte vectors
        for (int i = 0; i < 5; i++) begin
            rx_ignore = vecs[i].ign;
            push(vecs[i].data, 1'b1);
            wait_idle("vec_idle", 60);
            check("vec_rx_valid", rx_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check("vec_rd_data", rd_data, vecs[i].data);
            drain_rx("vec");
        end
        rx_ignore = 1'b0;

`ifdef SPI_RXFIFO_EN
        // RX full stalls the launch; one pop resumes exactly one transfer
        ts0 = ts_cyc.size();
        push(8'hB0, 1'b1);
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        step(30);
        push(8'hB3, 1'b1);
        push(8'hB4, 1'b1);
        push(8'hB5, 1'b1);
        step(120);
        check("stall_count", ts_cyc.size() - ts0, 4);
        check("stall_active", active, 1);
        rd_check("stall_pop");
        step(40);
        check("resume_one", ts_cyc.size() - ts0, 5);
        step(40);
        check("resume_only_one", ts_cyc.size() - ts0, 5);
        rd_check("stall_pop2");
        wait_idle("stall_idle", 100);
        check("stall_total", ts_cyc.size() - ts0, 6);
        drain_rx("stall");
`endif

        // Reset in the middle of a transfer
        push(8'h77, 1'b1);
        push(8'h78, 1'b1);
        wait_busy("rst_busy_rise", 1'b1, 10);
        step(3);
        ts0 = ts_cyc.size();
        rst_n = 1'b0;
        #1;
        tx_exp.delete();
        rx_exp.delete();
        check("midrst_txstart", txstart, 0);
        check("midrst_active", active, 0);
        check("midrst_tx_full", tx_full, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_txdata", txdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(30);
        check("postrst_active", active, 0);
        check("postrst_no_txstart", ts_cyc.size() - ts0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
